cla_pipe_addsub: RTL and testbench

- Parametrised successor to the 4-bit carry-lookahead adder.
- WIDTH-bit add/subtract built from 4-bit CLA groups. Each group sits in its own pipeline stage; the group carry is registered between stages and the operands are skewed.
- Valid/ready handshake on input and output, with full backpressure. Throughput is one operation per cycle.
- Used as the shared arithmetic unit feeding the datapath blocks.

---
 rtl/cla_pipe_addsub.sv | 241 ++++++++++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe_addsub
// Description : Pipelined WIDTH-bit adder/subtractor built from 4-bit
//               carry-lookahead groups. Stage k holds the not-yet-consumed
//               operand slices, the carry into group k and the sum bits
//               already produced. It resolves group k and hands the result to
//               stage k+1. A final output register holds {carry, sum}. Every
//               stage has a valid/ready handshake with full backpressure, so
//               the unit sustains one operation per cycle.
//
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               in_valid / in_ready - operand beat handshake
//               a, b                - WIDTH-bit operands
//               cin                 - carry-in (ignored when sub = 1)
//               sub                 - 1: a - b, 0: a + b + cin
//               out_valid/out_ready - result handshake
//               s                   - WIDTH+1-bit result, s[WIDTH] = carry-out
//               ovf                 - signed overflow flag (only when the
//                                     CLA_PIPE_OVF_FLAG_EN macro is defined)
//
// Config      : `define CLA_PIPE_OVF_FLAG_EN to add the ovf output.
// Parameters  : WIDTH must be a multiple of 4 and at least 4.
//
// Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s
`ifdef CLA_PIPE_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NGRP = WIDTH / 4;

  // 4-bit lookahead group. Returns {carry_out, sum[3:0]}. Every carry is a
  // flat sum of products of the generate/propagate terms; there is no ripple
  // through the group.
  function automatic logic [4:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       ci);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:1] c;
    p    = x ^ y;
    g    = x & y;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ {c[3:1], ci}};
  endfunction

  // --------------------------------------------------------------------------
  // Handshake. Index NGRP is the output register; indices 0..NGRP-1 are the
  // group stages. A stage can take new data when it is empty or when the
  // stage after it is moving, which unrolls to: ready unless every stage from
  // here to the output is full and the output is blocked.
  // --------------------------------------------------------------------------
  logic [NGRP:0] v_q;
  logic [NGRP:0] v_d;
  logic [NGRP:0] rdy;
  logic [NGRP:0] ld;

  always_comb begin : p_rdy
    logic all_full;
    all_full = 1'b1;
    for (int k = NGRP; k >= 0; k--) begin
      all_full = all_full & v_q[k];
      rdy[k]   = out_ready | ~all_full;
    end
  end

  // Data registers load only when a valid beat actually moves in, so s and
  // the stage contents stay put across bubbles and stalls.
  assign ld = rdy & {v_q[NGRP-1:0], in_valid};

  always_comb begin
    v_d = (v_q & ~rdy) | ({v_q[NGRP-1:0], in_valid} & rdy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[NGRP];

  // --------------------------------------------------------------------------
  // Group stages. Operand registers shrink by one group per stage: bit 0 of
  // stage k's operand registers is operand bit 4k.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    localparam int RW = WIDTH - 4 * k;

    logic [RW-1:0] a_q;
    logic [RW-1:0] a_d;
    logic [RW-1:0] bb_q;
    logic [RW-1:0] bb_d;
    logic          c_q;
    logic          c_d;
    logic [4:0]    grp;

    assign grp = cla4(a_q[3:0], bb_q[3:0], c_q);

    if (k == 0) begin : g_first
      // Subtraction is a + ~b + 1; cin only matters in add mode.
      always_comb begin
        a_d  = a_q;
        bb_d = bb_q;
        c_d  = c_q;
        if (ld[0]) begin
          a_d  = a;
          bb_d = sub ? ~b : b;
          c_d  = sub ? 1'b1 : cin;
        end
      end
    end else begin : g_next
      always_comb begin
        a_d  = a_q;
        bb_d = bb_q;
        c_d  = c_q;
        if (ld[k]) begin
          a_d  = g_stage[k-1].a_q[RW+3:4];
          bb_d = g_stage[k-1].bb_q[RW+3:4];
          c_d  = g_stage[k-1].grp[4];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q  <= '0;
        bb_q <= '0;
        c_q  <= 1'b0;
      end else begin
        a_q  <= a_d;
        bb_q <= bb_d;
        c_q  <= c_d;
      end
    end

    // Completed low-order sum bits; stage 0 has none yet.
    if (k > 0) begin : g_sum
      logic [4*k-1:0] sum_q;
      logic [4*k-1:0] sum_d;

      if (k == 1) begin : g_lo
        always_comb begin
          sum_d = ld[k] ? g_stage[0].grp[3:0] : sum_q;
        end
      end else begin : g_hi
        always_comb begin
          sum_d = ld[k] ? {g_stage[k-1].grp[3:0], g_stage[k-1].g_sum.sum_q}
                        : sum_q;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q <= '0;
        end else begin
          sum_q <= sum_d;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register: last group's carry and sum on top of the earlier bits.
  // --------------------------------------------------------------------------
  logic [WIDTH:0] s_q;
  logic [WIDTH:0] s_d;

  if (NGRP == 1) begin : g_out_single
    always_comb begin
      s_d = ld[NGRP] ? g_stage[0].grp : s_q;
    end
  end else begin : g_out_multi
    always_comb begin
      s_d = ld[NGRP] ? {g_stage[NGRP-1].grp, g_stage[NGRP-1].g_sum.sum_q}
                     : s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign s = s_q;

`ifdef CLA_PIPE_OVF_FLAG_EN
  // Carry into the MSB is recovered from the MSB sum bit:
  // s[MSB] = a ^ bb ^ c_in  =>  c_in = s[MSB] ^ a ^ bb.
  logic ovf_q;
  logic ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ld[NGRP]) begin
      ovf_d = g_stage[NGRP-1].grp[4] ^ g_stage[NGRP-1].grp[3]
            ^ g_stage[NGRP-1].a_q[3] ^ g_stage[NGRP-1].bb_q[3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_pipe_addsub
// Description : Self-checking bench for cla_pipe_addsub (WIDTH = 16).
//               Expected results are queued when a beat is accepted and are
//               compared when the matching result leaves the unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_addsub;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   s;
`ifdef CLA_PIPE_OVF_FLAG_EN
  logic             ovf;
`endif

  cla_pipe_addsub #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s)
`ifdef CLA_PIPE_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [WIDTH:0] s;
    logic           ovf;
    int             acc;   // cycle number of the accepting edge
    bit             lat;   // check latency for this beat
    bit             gap;   // must follow the previous result with no bubble
  } exp_t;

  exp_t sb[$];
  int   last_pop = 0;

  // Reference arithmetic: a + (b or ~b) + carry, and signed overflow from
  // operand/result sign bits.
  function automatic logic [WIDTH:0] model_s(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic ci, input logic sb_);
    logic [WIDTH-1:0] yy;
    yy = sb_ ? ~y : y;
    return {1'b0, x} + {1'b0, yy} + (WIDTH+1)'(sb_ ? 1'b1 : ci);
  endfunction

  function automatic logic model_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic ci, input logic sb_);
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   r;
    yy = sb_ ? ~y : y;
    r  = model_s(x, y, ci, sb_);
    return (x[WIDTH-1] == yy[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Present one beat, wait (bounded) for acceptance, queue its expectation.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                      input logic tcin, input logic tsub,
                      input logic [WIDTH:0] es, input logic eovf,
                      input bit lat, input bit gap);
    int waited;
    exp_t e;
    in_valid = 1'b1;
    a        = ta;
    b        = tbv;
    cin      = tcin;
    sub      = tsub;
    waited   = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 50);
    check_eq("accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      e.s   = es;
      e.ovf = eovf;
      e.acc = cyc + 1;
      e.lat = lat;
      e.gap = gap;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain", sb.size(), 32'd0);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", {31'd0, out_valid}, 32'd0);
      end else if (out_ready) begin
        e = sb.pop_front();
        check_eq("result_s", 32'(s), 32'(e.s));
`ifdef CLA_PIPE_OVF_FLAG_EN
        check_eq("result_ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
        if (e.lat) check_eq("latency", cyc - e.acc, LAT);
        if (e.gap) check_eq("gap", cyc - last_pop, 32'd1);
        last_pop = cyc;
      end else begin
        check_eq("stall_hold", 32'(s), 32'(sb[0].s));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic             rs;
    int               stale;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_s", 32'(s), 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef CLA_PIPE_OVF_FLAG_EN
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed beats, each on an empty pipe so the latency is exact.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0, 1'b1, 1'b0);
    wait_drain();
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE, 1'b0, 1'b1, 1'b0);
    wait_drain();
    send(16'h0007, 16'h0005, 1'b1, 1'b1, 17'h10002, 1'b0, 1'b1, 1'b0);
    wait_drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1, 1'b1, 1'b0);
    wait_drain();
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1, 1'b1, 1'b0);
    wait_drain();
    send(16'h0003, 16'h0002, 1'b0, 1'b0, 17'h00005, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Back-to-back: a=i, b=2i, cin=i[0] gives 3i+i[0], one per cycle.
    for (int i = 0; i < 8; i++) begin
      send(WIDTH'(i), WIDTH'(2 * i), i[0], 1'b0,
           (WIDTH+1)'(3 * i + (i % 2)), 1'b0, 1'b1, i != 0);
    end
    wait_drain();

    // Backpressure: fill all five registers, hold the output for 5 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      send(ra, rb, rc, rs, model_s(ra, rb, rc, rs), model_ovf(ra, rb, rc, rs),
           1'b0, 1'b0);
    end
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check_eq("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Reset with three beats in flight: they must vanish.
    for (int i = 0; i < 3; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      send(ra, rb, 1'b0, 1'b0, model_s(ra, rb, 1'b0, 1'b0),
           model_ovf(ra, rb, 1'b0, 1'b0), 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_s", 32'(s), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_eq("no_stale", stale, 32'd0);
    @(posedge clk);
    #1;

    // The unit keeps working after the reset.
    send(16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556, 1'b0, 1'b1, 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
